// File: rtl/adc_window_sum.sv
// adc_window_sum: moving-window accumulator over the last W ADC samples.
// Optional absolute-deviation mode sums |data_in - MIDSCALE| instead of raw codes.
//
// Handshake: a sample is accepted on a rising clk edge when data_valid is high
// while busy (FILL or RUN), start is high and clear is low; sum_valid is a
// one-cycle strobe marking the cycle in which sum_out was updated.
module adc_window_sum #(
  parameter int DATA_W   = 10,
  parameter int MAX_WIN  = 255,
  parameter int MIDSCALE = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear,
  input  logic [7:0]        window_width,
  input  logic              absolute_value,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [31:0]       sum_out,
  output logic              sum_valid,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int XW    = DATA_W + 1;
  localparam int ACC_W = 18;
  localparam logic [XW-1:0] MID_S = XW'(MIDSCALE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   sum_q;
  logic               sum_valid_q;
  logic [7:0]         ptr_q;
  logic [7:0]         fill_cnt_q;
  logic [7:0]         we_q;
  logic               abs_q;

  // The buffer holds raw codes; the term is recomputed on read with the
  // latched mode, so an abs term of MIDSCALE never needs an extra bit.
  logic [DATA_W-1:0]  buf_mem [MAX_WIN];

  logic               accept;
  logic               fill_last;
  logic [XW-1:0]      x_new;
  logic [XW-1:0]      x_old;
  logic [ACC_W-1:0]   acc_next;
  logic [7:0]         ptr_next;

  // Sample term: raw code or |d - MIDSCALE| in DATA_W+1 signed arithmetic.
  function automatic logic [XW-1:0] term(input logic [DATA_W-1:0] d, input logic m);
    logic signed [XW-1:0] diff;
    logic [XW-1:0]        res;
    diff = $signed({1'b0, d}) - $signed(MID_S);
    if (!m) res = {1'b0, d};
    else if (diff[XW-1]) res = $unsigned(-diff);
    else res = $unsigned(diff);
    return res;
  endfunction

  assign accept    = !clear && start && data_valid && (state_q != S_IDLE);
  assign fill_last = ({1'b0, fill_cnt_q} + 9'd1) == {1'b0, we_q};
  assign x_new     = term(data_in, abs_q);
  // Slot at ptr is stale during FILL, so its contribution is forced to zero.
  assign x_old     = (state_q == S_RUN) ? term(buf_mem[ptr_q], abs_q) : '0;
  assign acc_next  = acc_q + ACC_W'(x_new) - ACC_W'(x_old);
  assign ptr_next  = (ptr_q == we_q - 8'd1) ? 8'd0 : ptr_q + 8'd1;

  assign sum_out   = {{(32-ACC_W){1'b0}}, sum_q};
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; clear dominates, start low always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_FILL;
        S_FILL:  if (!start) state_d = S_IDLE;
                 else if (data_valid && fill_last) state_d = S_RUN;
        S_RUN:   if (!start) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Window datapath: accumulator, pointer, fill count, config latch, output sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      fill_cnt_q  <= '0;
      we_q        <= 8'd1;
      abs_q       <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (clear) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      fill_cnt_q  <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      fill_cnt_q  <= '0;
      sum_valid_q <= 1'b0;
      if (start) begin
        we_q  <= (window_width == 8'd0) ? 8'd1 : window_width;
        abs_q <= absolute_value;
      end
    end else if (!start) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      fill_cnt_q  <= '0;
      sum_valid_q <= 1'b0;
    end else if (data_valid) begin
      acc_q <= acc_next;
      ptr_q <= ptr_next;
      if (state_q == S_FILL) fill_cnt_q <= fill_cnt_q + 8'd1;
      if (state_q == S_RUN || fill_last) begin
        sum_q       <= acc_next;
        sum_valid_q <= 1'b1;
      end else begin
        sum_valid_q <= 1'b0;
      end
    end else begin
      sum_valid_q <= 1'b0;
    end
  end

  // Sample buffer write; contents survive reset and are refilled before use.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_adc_window_sum.sv
// Testbench for adc_window_sum: directed test-plan sequences with literal
// expected sums plus randomized traffic against a queue-based window model.
module tb_adc_window_sum;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  window_width = 8'd0;
  logic        absolute_value = 1'b0;
  logic [9:0]  data_in = 10'd0;
  logic        data_valid = 1'b0;
  logic [31:0] sum_out;
  logic        sum_valid;
  logic        busy;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  adc_window_sum dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .window_width(window_width), .absolute_value(absolute_value),
    .data_in(data_in), .data_valid(data_valid),
    .sum_out(sum_out), .sum_valid(sum_valid), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_busy = 0;
  int          m_we = 1;
  bit          m_abs = 0;
  int          m_win[$];
  logic [31:0] m_sum = 0;
  bit          m_valid = 0;

  function automatic int f_term(input int d, input bit a);
    if (!a) return d;
    return (d >= 512) ? d - 512 : 512 - d;
  endfunction

  function automatic logic [31:0] f_sum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return 32'(s);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_win.delete(); m_sum = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (clear) begin
        m_busy = 0; m_win.delete(); m_sum = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_we = (window_width == 0) ? 1 : int'(window_width);
          m_abs = absolute_value;
          m_win.delete();
        end
      end else if (!start) begin
        m_busy = 0; m_win.delete();
      end else if (data_valid) begin
        m_win.push_back(f_term(int'(data_in), m_abs));
        if (m_win.size() > m_we) void'(m_win.pop_front());
        if (m_win.size() == m_we) begin
          m_sum = f_sum(m_win);
          m_valid = 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("sum_out", sum_out, m_sum);
    chk("sum_valid", {31'd0, sum_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (sum_valid && exp_q.size() > 0) chk("literal_sum", sum_out, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit s, input bit c, input bit dv, input int d);
    start = s; clear = c; data_valid = dv; data_in = 10'(d);
    @(posedge clk); #2;
  endtask

  task automatic begin_run(input int w, input bit a);
    window_width = 8'(w); absolute_value = a;
    step(1, 0, 0, 0);
  endtask

  task automatic end_run();
    step(0, 0, 0, 0);
    chk("literal_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step(0, 0, 0, 0);
    chk("reset_sum", sum_out, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Raw, W=4, samples 1..6.
    exp_q = '{32'd10, 32'd14, 32'd18};
    begin_run(4, 0);
    for (int i = 1; i <= 6; i++) step(1, 0, 1, i);
    end_run();

    // Abs, W=2.
    exp_q = '{32'd24, 32'd12, 32'd512};
    begin_run(2, 1);
    step(1, 0, 1, 500); step(1, 0, 1, 524); step(1, 0, 1, 512); step(1, 0, 1, 0);
    end_run();

    // W=3 with data_valid toggling.
    exp_q = '{32'd60, 32'd90};
    begin_run(3, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, 10 * i);
      step(1, 0, 0, 999);
    end
    chk("toggle_hold", sum_out, 32'd90);
    end_run();

    // W=255, 300 samples of 1023: 46 identical full-window sums.
    exp_q.delete();
    for (int i = 0; i < 46; i++) exp_q.push_back(32'd260865);
    begin_run(255, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1023);
    end_run();

    // W=0 behaves as W=1.
    exp_q = '{32'd7, 32'd9};
    begin_run(0, 0);
    step(1, 0, 1, 7); step(1, 0, 1, 9);
    end_run();

    // Restart mid-RUN with a narrower window; old samples must not leak in.
    exp_q = '{32'd10, 32'd14, 32'd300, 32'd500};
    begin_run(4, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 1, i);
    step(0, 0, 1, 77);
    begin_run(2, 0);
    step(1, 0, 1, 100); step(1, 0, 1, 200); step(1, 0, 1, 300);
    end_run();

    // Asynchronous reset mid-run.
    begin_run(4, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 50 + i);
    reset_n = 1'b0;
    #1;
    chk("async_rst_sum", sum_out, 32'd0);
    chk("async_rst_valid", {31'd0, sum_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    #1 reset_n = 1'b1;
    step(0, 0, 0, 0);

    // Same sequence with clear: effect lands one edge later.
    begin_run(4, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 50 + i);
    step(1, 1, 1, 60);
    chk("clear_sum", sum_out, 32'd0);
    chk("clear_valid", {31'd0, sum_valid}, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 0, 0);

    // Randomized traffic against the model.
    exp_q.delete();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        window_width = 8'($urandom_range(0, 255));
      else
        window_width = 8'($urandom_range(0, 8));
      absolute_value = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)));
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
